pn8_ber_checker: RTL
====================

Name: pn8_ber_checker

Overview:
- Receive-side companion to the 8-bit PN transmitter, which sends the PN-255 sequence x^8+x^6+x^5+x^4+1 LSB-first on q.
- Takes the recovered NRZ bit stream, self-synchronises a local copy of the PN sequence, and counts bit errors over fixed measurement windows.
- Reports lock status and per-window error counts to the measurement/display logic downstream.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions needed, after the history is full, to declare lock.
- WINDOW, 255: received bits per measurement window (one full PN period by default).
- LOSS_THR, 32: errors within one window that force loss of lock.
- CNT_W, 16: width of the window bit counter and error counters. Must satisfy 2^CNT_W > WINDOW.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-low reset.
- resync  in  1  synchronous, active-high; forces a return to SEARCH.
- din  in  1  received PN bit.
- din_valid  in  1  strobe; din is sampled only on clock edges where this is high.
- locked  out  1  high while in LOCKED state.
- err_pulse  out  1  one-cycle pulse, one cycle after a LOCKED-state strobe whose bit mismatched.
- result_valid  out  1  one-cycle pulse when a window completes.
- result_err  out  CNT_W  error count of the last completed window; held until the next completion.
- lock_lost  out  1  one-cycle pulse on a LOCKED->SEARCH transition caused by the error threshold.

Behaviour:
- Reset (areset low, asynchronous): h=0, fill_cnt=0, match_cnt=0, bit_cnt=0, err_cnt=0, state=SEARCH. All outputs are 0.
- History h[7:0]: h[0] is the most recent bit. Predicted bit pred = h[1]^h[2]^h[3]^h[7]. These taps match the transmitter recurrence q(n)=q(n-2)^q(n-3)^q(n-4)^q(n-8).
- Nothing changes on cycles without din_valid, apart from pulses returning to 0.
- SEARCH state, per strobe:
  - h <= {h[6:0],din}.
  - While fill_cnt<8: fill_cnt++, match_cnt=0.
  - Otherwise, if din==pred and h!=0: match_cnt++. Else match_cnt=0. The h!=0 condition rejects the all-zero lockup pattern.
  - On the strobe where match_cnt reaches LOCK_CNT: state=LOCKED, and bit_cnt and err_cnt are cleared. locked rises on the following clock edge.
- LOCKED state, per strobe:
  - h <= {h[6:0],pred}. The local generator free-runs, so a channel error does not corrupt it.
  - e = din^pred. err_pulse <= e.
  - bit_cnt_next = bit_cnt+1. err_next = err_cnt+e.
  - If err_next >= LOSS_THR: state=SEARCH, fill_cnt=0, match_cnt=0, counters cleared, lock_lost pulse. No result_valid for the partial window. This takes priority over window completion on the same strobe.
  - Else if bit_cnt_next == WINDOW: result_err <= err_next, result_valid pulse, bit_cnt=0, err_cnt=0.
  - Else: bit_cnt = bit_cnt_next, err_cnt = err_next.
- resync high: on the next edge, state=SEARCH, fill_cnt=0, match_cnt=0, bit_cnt=0, err_cnt=0. It overrides any same-cycle strobe, does not pulse lock_lost, and leaves result_err unchanged.
- Latency:
  - locked rises 1 clk after the locking strobe.
  - err_pulse and result_valid appear 1 clk after their strobe.
- Window counters never wrap, because bit_cnt is cleared at WINDOW. err_cnt is bounded by LOSS_THR. Neither saturates.
- areset low mid-window drops every output to 0 immediately, with no result reported.

Test Plan:
- Feed transmitter output (seed 0x01) with din_valid high every cycle -> locked rises 1 clk after strobe 24 (8 fill + 16 matches). result_valid then fires every 255 strobes with result_err=0; err_pulse stays 0.
- After lock, invert one bit at window bit 100 -> exactly one err_pulse, 1 clk later. That window reports result_err=1, the next window reports 0, and locked stays high.
- After lock, hold din=0 -> 128 mismatches per 255 bits. lock_lost pulses and locked falls within one window, on the 32nd error; no result_valid for that window. din remains 0, so it never relocks.
- din_valid high only every 3rd cycle with a clean PN stream -> same lock point measured in strobes (24). Windows close every 255 strobes (765 clks) with result_err=0.
- Assert resync for 1 cycle while locked -> locked falls next edge with no lock_lost pulse. With the stream continuing, relock occurs 24 strobes later; result_err keeps its previous value.
- Drop areset asynchronously mid-window -> all outputs 0 immediately. After release, reacquisition takes 24 strobes.

Source files
------------

// File: rtl/pn8_ber_checker.sv
// PN-255 (x^8+x^6+x^5+x^4+1) receive checker: self-syncs a local generator, counts bit errors per window.
// Latency: locked, err_pulse, result_valid and lock_lost are registered, 1 clk after the causing strobe.
// Backpressure: none; din is consumed on every din_valid strobe, and the block never stalls the source.
//
// Ports:
//   clk          rising-edge system clock
//   areset       asynchronous active-low reset
//   resync       synchronous return to SEARCH; overrides a same-cycle strobe
//   din          received PN bit, sampled when din_valid is high
//   din_valid    input strobe
//   locked       high while the local generator is locked
//   err_pulse    1-clk pulse after a locked strobe whose bit mismatched
//   result_valid 1-clk pulse when a measurement window completes
//   result_err   error count of the last completed window (held)
//   lock_lost    1-clk pulse when the error threshold drops lock
module pn8_ber_checker #(
  parameter int LOCK_CNT = 16,
  parameter int WINDOW   = 255,
  parameter int LOSS_THR = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             resync,
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_err,
  output logic             lock_lost
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  localparam logic S_SEARCH = 1'b0;
  localparam logic S_LOCKED = 1'b1;

  localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] WIN_C     = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] THR_C     = CNT_W'(LOSS_THR);

  logic             state;
  logic [7:0]       h;          // h[0] is the most recent bit
  logic [3:0]       fill_cnt;
  logic [MW-1:0]    match_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;

  logic             pred;
  logic             e;
  logic [CNT_W-1:0] bit_cnt_next;
  logic [CNT_W-1:0] err_next;

  // Taps mirror the transmitter recurrence q(n)=q(n-2)^q(n-3)^q(n-4)^q(n-8).
  assign pred         = h[1] ^ h[2] ^ h[3] ^ h[7];
  assign e            = din ^ pred;
  assign bit_cnt_next = bit_cnt + CNT_W'(1);
  assign err_next     = err_cnt + CNT_W'(e);

  assign locked = (state == S_LOCKED);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state        <= S_SEARCH;
      h            <= 8'd0;
      fill_cnt     <= 4'd0;
      match_cnt    <= '0;
      bit_cnt      <= '0;
      err_cnt      <= '0;
      err_pulse    <= 1'b0;
      result_valid <= 1'b0;
      result_err   <= '0;
      lock_lost    <= 1'b0;
    end else begin
      err_pulse    <= 1'b0;
      result_valid <= 1'b0;
      lock_lost    <= 1'b0;
      if (resync) begin
        state     <= S_SEARCH;
        fill_cnt  <= 4'd0;
        match_cnt <= '0;
        bit_cnt   <= '0;
        err_cnt   <= '0;
      end else if (din_valid) begin
        if (state == S_SEARCH) begin
          h <= {h[6:0], din};
          if (!fill_cnt[3]) begin
            // History not yet fully populated with received bits.
            fill_cnt  <= fill_cnt + 4'd1;
            match_cnt <= '0;
          end else if ((din == pred) && (h != 8'd0)) begin
            // h==0 would predict zeros forever; never accept it as lock.
            if (match_cnt == LOCK_LAST) begin
              state     <= S_LOCKED;
              match_cnt <= '0;
              bit_cnt   <= '0;
              err_cnt   <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end else begin
            match_cnt <= '0;
          end
        end else begin
          // Free-running generator: feed back the prediction, not din,
          // so channel errors cannot corrupt the reference.
          h         <= {h[6:0], pred};
          err_pulse <= e;
          if (err_next >= THR_C) begin
            state     <= S_SEARCH;
            fill_cnt  <= 4'd0;
            match_cnt <= '0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            lock_lost <= 1'b1;
          end else if (bit_cnt_next == WIN_C) begin
            result_err   <= err_next;
            result_valid <= 1'b1;
            bit_cnt      <= '0;
            err_cnt      <= '0;
          end else begin
            bit_cnt <= bit_cnt_next;
            err_cnt <= err_next;
          end
        end
      end
    end
  end

endmodule
